// File: rtl/ram_debug_dumper_if.sv
// rtl/ram_debug_dumper_if.sv - dump stream bundle between the dumper and its consumer
//
// Purpose: carries one word of the dump stream per valid/ready handshake.
// Signals:
//   out_valid  master->slave  stream word is valid
//   out_ready  slave->master  consumer accepts the word
//   out_addr   master->slave  byte address of the word
//   out_data   master->slave  word read from the selected RAM
interface ram_debug_dumper_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/ram_debug_dumper.sv
// rtl/ram_debug_dumper.sv - streams a window of Data/Inst RAM words out through the debug ports
//
// Purpose: on a start pulse, reads word_count words starting at base_word from the
// selected RAM's second (debug) port and presents each one on the dump stream,
// holding the CPU in reset for the duration.
// Ports:
//   CPU_CLK, CPU_RST_N         clock, asynchronous active-low reset
//   start, ram_sel             dump request; 0 = Data RAM, 1 = Inst RAM
//   base_word, word_count      first word index and number of words (0..4096)
//   CPU_Debug_*RAM_A2/WE2/WD2  debug port address (bytes), write enables, write data
//   CPU_Debug_*RAM_RD2         debug port read data
//   cpu_hold, busy, done       core stall, activity flag, end-of-dump pulse
//   dump                       output stream (out_valid/out_ready/out_addr/out_data)
module ram_debug_dumper #(
    parameter int BRAMWORDS  = 4096,
    parameter int RD_LATENCY = 2
) (
    input  logic               CPU_CLK,
    input  logic               CPU_RST_N,
    input  logic               start,
    input  logic               ram_sel,
    input  logic [11:0]        base_word,
    input  logic [12:0]        word_count,
    output logic [31:0]        CPU_Debug_DataRAM_A2,
    output logic [3:0]         CPU_Debug_DataRAM_WE2,
    output logic [31:0]        CPU_Debug_DataRAM_WD2,
    input  logic [31:0]        CPU_Debug_DataRAM_RD2,
    output logic [31:0]        CPU_Debug_InstRAM_A2,
    output logic [3:0]         CPU_Debug_InstRAM_WE2,
    output logic [31:0]        CPU_Debug_InstRAM_WD2,
    input  logic [31:0]        CPU_Debug_InstRAM_RD2,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    ram_debug_dumper_if.master dump
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [11:0] LP_IDX_MAX   = 12'(BRAMWORDS - 1);
    localparam logic [2:0]  LP_WAIT_INIT = 3'(RD_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_sel;
    logic [11:0] r_idx;
    logic [12:0] r_count;
    logic [12:0] r_n;
    logic [2:0]  r_wait;
    logic [31:0] r_data_a2;
    logic [31:0] r_inst_a2;
    logic [31:0] r_out_addr;
    logic [31:0] r_out_data;

    logic [11:0] w_base_idx;
    logic [12:0] w_n_inc;
    logic        w_last;
    logic        w_handshake;
    logic [31:0] w_issue_a2;
    logic [31:0] w_sel_a2;
    logic [31:0] w_sel_rd;

    // base_word is already below 4096; the modulo only matters for smaller RAMs
    assign w_base_idx  = 12'({20'd0, base_word} % 32'(BRAMWORDS));
    assign w_n_inc     = r_n + 13'd1;
    assign w_last      = (w_n_inc == r_count);
    assign w_handshake = (r_state == S_PRESENT) && dump.out_ready;
    assign w_issue_a2  = {18'd0, r_idx, 2'b00};
    assign w_sel_a2    = r_sel ? r_inst_a2 : r_data_a2;
    assign w_sel_rd    = r_sel ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = (word_count == 13'd0) ? S_DONE : S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (r_wait == 3'd0) w_next = S_PRESENT;
            S_PRESENT: if (dump.out_ready) w_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_sel      <= 1'b0;
            r_idx      <= 12'd0;
            r_count    <= 13'd0;
            r_n        <= 13'd0;
            r_wait     <= 3'd0;
            r_data_a2  <= 32'd0;
            r_inst_a2  <= 32'd0;
            r_out_addr <= 32'd0;
            r_out_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // parameters are only captured here, so later input changes are harmless
                    if (start) begin
                        r_sel   <= ram_sel;
                        r_idx   <= w_base_idx;
                        r_count <= word_count;
                        r_n     <= 13'd0;
                    end
                end
                S_ISSUE: begin
                    // only the selected port moves; the other stays at 0 for the whole dump
                    if (r_sel) r_inst_a2 <= w_issue_a2;
                    else       r_data_a2 <= w_issue_a2;
                    r_wait <= LP_WAIT_INIT;
                end
                S_WAIT: begin
                    if (r_wait == 3'd0) begin
                        r_out_data <= w_sel_rd;
                        r_out_addr <= w_sel_a2;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                S_PRESENT: begin
                    if (w_handshake) begin
                        r_n   <= w_n_inc;
                        r_idx <= (r_idx == LP_IDX_MAX) ? 12'd0 : r_idx + 12'd1;
                    end
                end
                S_DONE: begin
                    // park both ports at 0 so an idle dumper never disturbs either RAM address
                    r_data_a2 <= 32'd0;
                    r_inst_a2 <= 32'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign CPU_Debug_DataRAM_A2  = r_data_a2;
    assign CPU_Debug_InstRAM_A2  = r_inst_a2;
    assign CPU_Debug_DataRAM_WE2 = 4'b0000;
    assign CPU_Debug_InstRAM_WE2 = 4'b0000;
    assign CPU_Debug_DataRAM_WD2 = 32'd0;
    assign CPU_Debug_InstRAM_WD2 = 32'd0;

    assign busy     = (r_state != S_IDLE);
    assign cpu_hold = busy;
    assign done     = (r_state == S_DONE);

    assign dump.out_valid = (r_state == S_PRESENT);
    assign dump.out_addr  = r_out_addr;
    assign dump.out_data  = r_out_data;

endmodule

// File: tb/tb_ram_debug_dumper.sv
// tb/tb_ram_debug_dumper.sv - scoreboard bench for ram_debug_dumper
module tb_ram_debug_dumper;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ram_sel = 1'b0;
    logic [11:0] base_word = 12'd0;
    logic [12:0] word_count = 13'd0;
    logic [31:0] d_a2, i_a2, d_wd, i_wd;
    logic [31:0] d_rd = 32'd0;
    logic [31:0] i_rd = 32'd0;
    logic [3:0]  d_we, i_we;
    logic        cpu_hold, busy, done;

    ram_debug_dumper_if dif();

    ram_debug_dumper #(.BRAMWORDS(4096), .RD_LATENCY(LAT)) dut (
        .CPU_CLK               (clk),
        .CPU_RST_N             (rst_n),
        .start                 (start),
        .ram_sel               (ram_sel),
        .base_word             (base_word),
        .word_count            (word_count),
        .CPU_Debug_DataRAM_A2  (d_a2),
        .CPU_Debug_DataRAM_WE2 (d_we),
        .CPU_Debug_DataRAM_WD2 (d_wd),
        .CPU_Debug_DataRAM_RD2 (d_rd),
        .CPU_Debug_InstRAM_A2  (i_a2),
        .CPU_Debug_InstRAM_WE2 (i_we),
        .CPU_Debug_InstRAM_WD2 (i_wd),
        .CPU_Debug_InstRAM_RD2 (i_rd),
        .cpu_hold              (cpu_hold),
        .busy                  (busy),
        .done                  (done),
        .dump                  (dif)
    );

    always #5 clk = ~clk;

    // RAM contents and a one-register read port: data for an address is visible
    // two cycles after the address changes
    logic [31:0] dmem [4096];
    logic [31:0] imem [4096];
    always @(posedge clk) begin
        d_rd <= dmem[d_a2[13:2]];
        i_rd <= imem[i_a2[13:2]];
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_done = 0;
    int          done_seen = 0;
    int          hs_count = 0;
    int          last_hs_cyc = 0;
    int          start_cyc = 0;
    int          done_dur = 0;
    int          rdy_mode = 0;
    logic        rnd_ready = 1'b1;
    logic        forced_ready = 1'b0;
    bit          cur_sel = 1'b0;
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    assign dif.out_ready = (rdy_mode == 2) ? forced_ready : rnd_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit sel, input int base, input int cnt);
        cur_sel = sel;
        for (int k = 0; k < cnt; k++) begin
            int idx;
            idx = (base + k) % 4096;
            exp_addr.push_back(32'(idx * 4));
            exp_data.push_back(sel ? imem[idx] : dmem[idx]);
        end
        exp_done++;
    endtask

    task automatic drive_start(input bit sel, input int base, input int cnt);
        ram_sel    = sel;
        base_word  = 12'(base);
        word_count = 13'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_cyc  = cyc;
        ram_sel    = 1'($urandom);
        base_word  = 12'($urandom);
        word_count = 13'($urandom);
    endtask

    task automatic wait_done;
        int t;
        t = 0;
        while (!done && t < 3000) begin
            tick();
            t++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("stream_drained", 32'(exp_addr.size()), 32'd0);
        done_dur = cyc - start_cyc;
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("hold_idle", 32'(cpu_hold), 32'd0);
    endtask

    task automatic run_dump(input bit sel, input int base, input int cnt);
        push_exp(sel, base, cnt);
        drive_start(sel, base, cnt);
        wait_done();
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) rnd_ready = 1'($urandom_range(0, 1));
        else               rnd_ready = 1'b1;
    end

    // stream monitor and per-cycle invariants
    initial begin
        logic        prev_stall;
        logic        prev_done;
        logic [31:0] p_addr, p_data;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        p_addr     = 32'd0;
        p_data     = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                check("data_we2", 32'(d_we), 32'd0);
                check("inst_we2", 32'(i_we), 32'd0);
                check("data_wd2", d_wd, 32'd0);
                check("inst_wd2", i_wd, 32'd0);
                if (busy) check("unselected_a2", cur_sel ? d_a2 : i_a2, 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(dif.out_valid), 32'd1);
                    check("stall_addr", dif.out_addr, p_addr);
                    check("stall_data", dif.out_data, p_data);
                end
                if (dif.out_valid && dif.out_ready) begin
                    n_checks++;
                    if (exp_addr.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got addr %h data %h expected no word", dif.out_addr, dif.out_data);
                    end else begin
                        logic [31:0] ea, ed;
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        if (dif.out_addr !== ea || dif.out_data !== ed) begin
                            n_fail++;
                            $display("FAIL stream_word: got (%h,%h) expected (%h,%h)", dif.out_addr, dif.out_data, ea, ed);
                        end
                    end
                    hs_count++;
                    last_hs_cyc = cyc + 1;
                end
                if (done) begin
                    done_seen++;
                    check("done_not_repeated", 32'(prev_done), 32'd0);
                end
                prev_stall = dif.out_valid && !dif.out_ready;
                p_addr     = dif.out_addr;
                p_data     = dif.out_data;
                prev_done  = done;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0d, a0i, sa, sd;
        int          h0, t;

        for (int i = 0; i < 4096; i++) begin
            dmem[i] = $urandom;
            imem[i] = $urandom;
        end
        dmem[0] = 32'd11;
        dmem[1] = 32'd22;
        dmem[2] = 32'd33;
        dmem[3] = 32'd44;
        imem[7] = 32'h0000_0013;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(dif.out_valid), 32'd0);
        check("rst_addr", dif.out_addr, 32'd0);
        check("rst_data", dif.out_data, 32'd0);
        check("rst_a2", d_a2 | i_a2, 32'd0);
        check("rst_flags", {29'd0, busy, cpu_hold, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // four Data RAM words, ready held high: four cycles per word
        run_dump(1'b0, 0, 4);
        check("total_cycles_4_words", 32'(last_hs_cyc - start_cyc), 32'd16);

        // index wrap past the top of the RAM
        run_dump(1'b0, 4094, 4);

        // zero-length dump: one busy cycle, address ports untouched
        a0d = d_a2;
        a0i = i_a2;
        push_exp(1'b0, 123, 0);
        drive_start(1'b0, 123, 0);
        check("zero_len_busy", 32'(busy), 32'd1);
        check("zero_len_hold", 32'(cpu_hold), 32'd1);
        wait_done();
        check("zero_len_duration", 32'(done_dur), 32'd0);
        check("zero_len_data_a2", d_a2, a0d);
        check("zero_len_inst_a2", i_a2, a0i);

        // single Inst RAM word
        run_dump(1'b1, 7, 1);

        // consumer stalls 5 cycles; a second start during the stall is ignored
        rdy_mode     = 2;
        forced_ready = 1'b0;
        push_exp(1'b0, 100, 2);
        drive_start(1'b0, 100, 2);
        t = 0;
        while (!dif.out_valid && t < 50) begin
            tick();
            t++;
        end
        check("stall_present", 32'(dif.out_valid), 32'd1);
        sa = dif.out_addr;
        sd = dif.out_data;
        check("stall_first_addr", sa, 32'd400);
        check("stall_first_data", sd, dmem[100]);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                ram_sel    = 1'b1;
                base_word  = 12'd500;
                word_count = 13'd7;
                start      = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("stall5_valid", 32'(dif.out_valid), 32'd1);
        check("stall5_addr", dif.out_addr, sa);
        check("stall5_data", dif.out_data, sd);
        forced_ready = 1'b1;
        wait_done();
        rdy_mode = 0;

        // reset during the second word's WAIT, then restart from a new base
        push_exp(1'b0, 10, 3);
        drive_start(1'b0, 10, 3);
        h0 = hs_count;
        t  = 0;
        while (hs_count == h0 && t < 50) begin
            tick();
            t++;
        end
        check("first_word_before_reset", 32'(hs_count - h0), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(dif.out_valid), 32'd0);
        check("abort_addr", dif.out_addr, 32'd0);
        check("abort_data", dif.out_data, 32'd0);
        check("abort_data_a2", d_a2, 32'd0);
        check("abort_inst_a2", i_a2, 32'd0);
        check("abort_flags", {29'd0, busy, cpu_hold, done}, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        exp_done--;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        push_exp(1'b1, 4000, 3);
        drive_start(1'b1, 4000, 3);
        check("first_start_after_reset", 32'(busy), 32'd1);
        wait_done();

        // randomized dumps with a randomly stalling consumer
        rdy_mode = 1;
        for (int r = 0; r < 40; r++) begin
            int b, c;
            bit s;
            s = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4085, 4095)) : int'($urandom_range(0, 4095));
            c = int'($urandom_range(0, 12));
            run_dump(s, b, c);
            repeat ($urandom_range(0, 3)) tick();
        end
        rdy_mode = 0;
        tick();

        check("done_pulse_count", 32'(done_seen), 32'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_debug_dumper.md
RAM_DEBUG_DUMPER -- requirements
Module: ram_debug_dumper

Interface
REQ-001 The block SHALL have parameter BRAMWORDS, default 4096, meaning the number of 32-bit words per RAM.
REQ-002 The block SHALL have parameter RD_LATENCY, default 2, meaning the cycles from A2 change to valid RD2 (range 1..7).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CPU_CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 CPU_RST_N  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle request to begin a dump; sampled in IDLE only.
REQ-007 ram_sel  in  1  0 = Data RAM, 1 = Inst RAM; captured with start.
REQ-008 base_word  in  12  first word index; captured with start.
REQ-009 word_count  in  13  number of words, 0..4096; captured with start.
REQ-010 CPU_Debug_DataRAM_A2 / CPU_Debug_InstRAM_A2  out  32 each  byte address to each debug port.
REQ-011 CPU_Debug_DataRAM_WE2 / CPU_Debug_InstRAM_WE2  out  4 each  write enables; constant 4'b0000.
REQ-012 CPU_Debug_DataRAM_WD2 / CPU_Debug_InstRAM_WD2  out  32 each  constant 0.
REQ-013 CPU_Debug_DataRAM_RD2 / CPU_Debug_InstRAM_RD2  in  32 each  read data from each debug port.
REQ-014 cpu_hold  out  1  high while busy; drives the core reset so the CPU is stalled during a dump.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when the last word is accepted, or for a zero-length dump.
REQ-017 out_valid  out  1  the stream word is valid.
REQ-018 out_ready  in  1  the consumer accepts the word.
REQ-019 out_addr  out  32  byte address of the word.
REQ-020 out_data  out  32  word read.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, PRESENT, DONE.
REQ-022 IDLE + start: the block SHALL capture ram_sel, base_word and word_count, then go to DONE if word_count==0, otherwise go to ISSUE.
REQ-023 ISSUE: the block SHALL drive the selected A2 = {idx,2'b00}, where idx = (base_word + n) mod BRAMWORDS for n = 0..count-1, load wait counter = RD_LATENCY-1, and go to WAIT.
REQ-024 WAIT: the block SHALL hold A2 stable and decrement the counter; at 0 it SHALL register the selected RD2 into out_data, set out_addr = A2, and go to PRESENT.
REQ-025 PRESENT: out_valid SHALL be 1, and out_addr/out_data SHALL be stable until the valid && ready handshake.
REQ-026 On handshake: n SHALL increment; the block SHALL go to DONE if n==count, else to ISSUE.
REQ-027 Per-word throughput SHALL be RD_LATENCY+2 cycles minimum with out_ready held high.
REQ-028 Index wrap: base_word + n SHALL wrap past BRAMWORDS-1 to 0 (12-bit modulo).
REQ-029 The unselected RAM's A2 SHALL stay 0 throughout a dump.
REQ-030 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; cpu_hold SHALL deassert on entry to IDLE.
REQ-031 start while busy SHALL be ignored, with no effect on captured parameters.
REQ-032 out_ready asserted outside PRESENT SHALL have no effect.
REQ-033 Changes on ram_sel, base_word or word_count after capture SHALL have no effect until the next dump.

Reset
REQ-034 While CPU_RST_N is 0 (asynchronous, at any state): state = IDLE, both A2 = 0, out_valid = 0, out_addr = 0, out_data = 0, busy = 0, cpu_hold = 0, done = 0, n = 0.
REQ-035 Reset mid-dump SHALL abort with no done pulse, and the stream SHALL be dropped immediately.
REQ-036 The first start SHALL be honoured on the first rising edge after CPU_RST_N rises.

Verification
REQ-037 Data RAM words 0..3 = 11,22,33,44; start with ram_sel=0, base=0, count=4, ready=1 -> stream (0,11),(4,22),(8,33),(C,44); done pulses once; total 16 cycles at RD_LATENCY=2.
REQ-038 base=4094, count=4 -> out_addr sequence 3FF8, 3FFC, 0000, 0004.
REQ-039 count=0 -> busy for 1 cycle, done pulse, out_valid never 1, A2 never changes.
REQ-040 ready held low for 5 cycles in PRESENT -> out_addr/out_data/out_valid unchanged for those 5 cycles; the second start pulse during the stall is ignored.
REQ-041 ram_sel=1, Inst RAM word 7 = 0x00000013, base=7, count=1 -> (0x1C, 0x00000013); DataRAM_A2 stays 0; both WE2 stay 0.
REQ-042 CPU_RST_N low during the 2nd WAIT -> all outputs 0 within the same cycle; no done pulse; a new start after release restarts from the new base.
